// File: rtl/tag_status_table_pkg.sv
// Shared types and default sizing for the tag status table.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tag_status_table_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_TAG_W    = 6;
    localparam int DEF_NUM_CDB  = 2;
    localparam int DEF_NUM_CKPT = 4;

    // Tags are stored zero-extended to this width so one entry type serves
    // every instance; TAG_W must not exceed it.
    localparam int TAG_W_MAX = 16;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
    } entry_t;

endpackage

// File: rtl/tag_status_table_match.sv
// Tag-to-register match for one CDB channel: per-entry hit vector plus lowest hit index.
// Latency: purely combinational.
// Backpressure: none.
module tst_tag_match
    import tag_status_table_pkg::*;
#(
    parameter int  NUM_REGS = DEF_NUM_REGS,
    parameter int  TAG_W    = DEF_TAG_W,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  entry_t [NUM_REGS-1:0] tbl_i,
    input  logic   [TAG_W-1:0]    tag_i,
    output logic                  hit_o,
    output logic   [RW-1:0]       idx_o,
    output logic   [NUM_REGS-1:0] match_o
);

    // Compare every valid entry against the broadcast tag
    always_comb begin
        match_o = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            match_o[r] = tbl_i[r].valid && (tbl_i[r].tag == TAG_W_MAX'(tag_i));
        end
    end

    // Encode the matching index; tags are unique so priority only matters for robustness
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int r = NUM_REGS - 1; r >= 0; r--) begin
            if (match_o[r]) begin
                hit_o = 1'b1;
                idx_o = RW'(r);
            end
        end
    end

endmodule

// File: rtl/tag_status_table.sv
// Register tag status table with CDB wakeup/clear, read bypass and branch checkpoints.
// Latency: lookups/rf_we combinational; table, checkpoint and pointer updates on next clk.
// Backpressure: none internal; dispatcher must stall saves while ckpt_full is high.
module tag_status_table
    import tag_status_table_pkg::*;
#(
    parameter int  NUM_REGS = DEF_NUM_REGS,
    parameter int  TAG_W    = DEF_TAG_W,
    parameter int  NUM_CDB  = DEF_NUM_CDB,
    parameter int  NUM_CKPT = DEF_NUM_CKPT,
    localparam int RW       = $clog2(NUM_REGS),
    localparam int CKW      = $clog2(NUM_CKPT),
    localparam int CNTW     = CKW + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CDB-1:0]             cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]  cdb_tag,
    output logic [NUM_CDB-1:0]             rf_we,
    output logic [NUM_CDB-1:0][RW-1:0]     rf_rd,
    input  logic [RW-1:0]                  rs1,
    input  logic [RW-1:0]                  rs2,
    output logic [TAG_W-1:0]               rs1_tag,
    output logic [TAG_W-1:0]               rs2_tag,
    output logic                           rs1_tag_valid,
    output logic                           rs2_tag_valid,
    input  logic [RW-1:0]                  rd,
    input  logic [TAG_W-1:0]               rd_tag,
    input  logic                           tag_write_en,
    input  logic                           ckpt_save,
    output logic [CKW-1:0]                 ckpt_id,
    output logic                           ckpt_full,
    input  logic                           ckpt_release,
    input  logic                           flush,
    input  logic [CKW-1:0]                 flush_id
);

    entry_t [NUM_REGS-1:0]               tbl_q, tbl_d;
    entry_t [NUM_CKPT-1:0][NUM_REGS-1:0] ckpt_q, ckpt_d, ckpt_clrd;
    logic   [CKW-1:0]                    head_q, head_d, tail_q, tail_d;
    logic   [CNTW-1:0]                   cnt_q, cnt_d;

    logic [NUM_CDB-1:0][NUM_REGS-1:0] match;
    logic [NUM_CDB-1:0]               hit;
    logic [NUM_REGS-1:0]              live_clr;
    logic                             save_ok;
    logic                             rel_ok;

    for (genvar c = 0; c < NUM_CDB; c++) begin : g_match
        tst_tag_match #(
            .NUM_REGS (NUM_REGS),
            .TAG_W    (TAG_W)
        ) u_match (
            .tbl_i   (tbl_q),
            .tag_i   (cdb_tag[c]),
            .hit_o   (hit[c]),
            .idx_o   (rf_rd[c]),
            .match_o (match[c])
        );
    end

    assign rf_we = cdb_valid & hit;

    // Merge all valid channels into one per-entry clear vector for the live table
    always_comb begin
        live_clr = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (cdb_valid[c]) begin
                live_clr |= match[c];
            end
        end
    end

    // Source reads report the stored tag but treat a same-cycle broadcast as already ready
    assign rs1_tag       = tbl_q[rs1].tag[TAG_W-1:0];
    assign rs2_tag       = tbl_q[rs2].tag[TAG_W-1:0];
    assign rs1_tag_valid = tbl_q[rs1].valid & ~live_clr[rs1];
    assign rs2_tag_valid = tbl_q[rs2].valid & ~live_clr[rs2];

    // Apply this cycle's broadcasts to every stored checkpoint so restores never revive a dead tag
    always_comb begin
        ckpt_clrd = ckpt_q;
        for (int s = 0; s < NUM_CKPT; s++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int c = 0; c < NUM_CDB; c++) begin
                    if (cdb_valid[c] && (ckpt_q[s][r].tag == TAG_W_MAX'(cdb_tag[c]))) begin
                        ckpt_clrd[s][r].valid = 1'b0;
                    end
                end
            end
        end
    end

    // Live table next state: clears, then dispatch write (wins over a clear), flush overrides all
    always_comb begin
        tbl_d = tbl_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (live_clr[r]) begin
                tbl_d[r].valid = 1'b0;
            end
        end
        if (flush) begin
            tbl_d = ckpt_clrd[flush_id];
        end else if (tag_write_en && (rd != '0)) begin
            tbl_d[rd].valid = 1'b1;
            tbl_d[rd].tag   = TAG_W_MAX'(rd_tag);
        end
    end

    assign ckpt_full = (cnt_q == CNTW'(NUM_CKPT));
    assign ckpt_id   = tail_q;
    assign rel_ok    = ckpt_release && (cnt_q != '0);
    assign save_ok   = ckpt_save && !ckpt_full && !flush;

    // Checkpoint ring pointers: release retires the head first, then flush rewinds the tail
    always_comb begin
        head_d = head_q + CKW'(rel_ok);
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush) begin
            tail_d = flush_id;
            cnt_d  = {1'b0, flush_id - head_d};
        end else begin
            if (save_ok) begin
                tail_d = tail_q + CKW'(1);
            end
            cnt_d = cnt_q + CNTW'(save_ok) - CNTW'(rel_ok);
        end
    end

    // Snapshot the post-update live table into the tail slot on an accepted save
    always_comb begin
        ckpt_d = ckpt_clrd;
        if (save_ok) begin
            ckpt_d[tail_q] = tbl_d;
        end
    end

    // State registers; reset drops every pending tag and checkpoint
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_q  <= '0;
            ckpt_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            tbl_q  <= tbl_d;
            ckpt_q <= ckpt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tag_status_table.sv
// Directed bench for tag_status_table with hand-computed expectations.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns later.
// Backpressure: n/a.
module tb_tag_status_table;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       cdb_valid;
    logic [1:0][5:0]  cdb_tag;
    logic [1:0]       rf_we;
    logic [1:0][4:0]  rf_rd;
    logic [4:0]       rs1, rs2;
    logic [5:0]       rs1_tag, rs2_tag;
    logic             rs1_tag_valid, rs2_tag_valid;
    logic [4:0]       rd;
    logic [5:0]       rd_tag;
    logic             tag_write_en;
    logic             ckpt_save;
    logic [1:0]       ckpt_id;
    logic             ckpt_full;
    logic             ckpt_release;
    logic             flush;
    logic [1:0]       flush_id;

    int n_cmp = 0;
    int n_err = 0;

    tag_status_table #(
        .NUM_REGS (32),
        .TAG_W    (6),
        .NUM_CDB  (2),
        .NUM_CKPT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .rf_we         (rf_we),
        .rf_rd         (rf_rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_tag       (rs1_tag),
        .rs2_tag       (rs2_tag),
        .rs1_tag_valid (rs1_tag_valid),
        .rs2_tag_valid (rs2_tag_valid),
        .rd            (rd),
        .rd_tag        (rd_tag),
        .tag_write_en  (tag_write_en),
        .ckpt_save     (ckpt_save),
        .ckpt_id       (ckpt_id),
        .ckpt_full     (ckpt_full),
        .ckpt_release  (ckpt_release),
        .flush         (flush),
        .flush_id      (flush_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        cdb_valid    = 2'b00;
        cdb_tag      = '0;
        rs1          = 5'd5;
        rs2          = 5'd0;
        rd           = 5'd0;
        rd_tag       = 6'd0;
        tag_write_en = 1'b0;
        ckpt_save    = 1'b0;
        ckpt_release = 1'b0;
        flush        = 1'b0;
        flush_id     = 2'd0;

        // reset state
        #2;
        chk("rst_rs1_vld", 32'(rs1_tag_valid), 0);
        chk("rst_rf_we",   32'(rf_we), 0);
        chk("rst_full",    32'(ckpt_full), 0);
        chk("rst_ckpt_id", 32'(ckpt_id), 0);
        tick();
        tick();
        rst = 1'b0;

        // write r5 tag 9, then broadcast tag 9
        rd = 5'd5; rd_tag = 6'd9; tag_write_en = 1'b1;
        tick();
        tag_write_en = 1'b0;
        #1;
        chk("a_rs1_vld", 32'(rs1_tag_valid), 1);
        chk("a_rs1_tag", 32'(rs1_tag), 9);
        cdb_valid = 2'b01; cdb_tag[0] = 6'd9;
        #1;
        chk("a_rf_we",      32'(rf_we), 2'b01);
        chk("a_rf_rd0",     32'(rf_rd[0]), 5);
        chk("a_bypass_vld", 32'(rs1_tag_valid), 0);
        chk("a_bypass_tag", 32'(rs1_tag), 9);
        tick();
        cdb_valid = 2'b00;
        #1;
        chk("a_cleared",    32'(rs1_tag_valid), 0);
        chk("a_rf_we_idle", 32'(rf_we), 0);

        // two channels clearing two entries in one cycle
        rd = 5'd2; rd_tag = 6'd3; tag_write_en = 1'b1;
        tick();
        rd = 5'd4; rd_tag = 6'd7;
        tick();
        tag_write_en = 1'b0;
        rs1 = 5'd2; rs2 = 5'd4;
        #1;
        chk("b_pre_rs1_vld", 32'(rs1_tag_valid), 1);
        chk("b_pre_rs2_vld", 32'(rs2_tag_valid), 1);
        cdb_valid = 2'b11; cdb_tag[0] = 6'd3; cdb_tag[1] = 6'd7;
        #1;
        chk("b_rf_we",  32'(rf_we), 2'b11);
        chk("b_rf_rd0", 32'(rf_rd[0]), 2);
        chk("b_rf_rd1", 32'(rf_rd[1]), 4);
        tick();
        cdb_valid = 2'b00;
        #1;
        chk("b_rs1_clr", 32'(rs1_tag_valid), 0);
        chk("b_rs2_clr", 32'(rs2_tag_valid), 0);

        // broadcast with no matching entry
        cdb_valid = 2'b01; cdb_tag[0] = 6'd33;
        #1;
        chk("nm_rf_we",  32'(rf_we), 0);
        chk("nm_rf_rd0", 32'(rf_rd[0]), 0);
        cdb_valid = 2'b00;

        // writes to r0 are dropped
        rd = 5'd0; rd_tag = 6'd10; tag_write_en = 1'b1;
        tick();
        tag_write_en = 1'b0;
        rs1 = 5'd0; cdb_valid = 2'b01; cdb_tag[0] = 6'd10;
        #1;
        chk("r0_vld",   32'(rs1_tag_valid), 0);
        chk("r0_rf_we", 32'(rf_we), 0);
        cdb_valid = 2'b00;

        // same-cycle dispatch and clear of r6: write wins, read bypass hides the old tag
        rd = 5'd6; rd_tag = 6'd4; tag_write_en = 1'b1;
        tick();
        rd_tag = 6'd12; cdb_valid = 2'b01; cdb_tag[0] = 6'd4; rs1 = 5'd6;
        #1;
        chk("c_bypass_vld", 32'(rs1_tag_valid), 0);
        chk("c_bypass_tag", 32'(rs1_tag), 4);
        chk("c_rf_we",      32'(rf_we), 2'b01);
        chk("c_rf_rd0",     32'(rf_rd[0]), 6);
        tick();
        tag_write_en = 1'b0; cdb_valid = 2'b00;
        #1;
        chk("c_r6_vld", 32'(rs1_tag_valid), 1);
        chk("c_r6_tag", 32'(rs1_tag), 12);

        // checkpoint r3 tag 5, overwrite with tag 8, flush back
        rd = 5'd3; rd_tag = 6'd5; tag_write_en = 1'b1;
        tick();
        tag_write_en = 1'b0; ckpt_save = 1'b1;
        #1;
        chk("d_ckpt_id", 32'(ckpt_id), 0);
        tick();
        ckpt_save = 1'b0;
        rd_tag = 6'd8; tag_write_en = 1'b1;
        tick();
        tag_write_en = 1'b0; rs1 = 5'd3; rs2 = 5'd6;
        #1;
        chk("d_pre_tag", 32'(rs1_tag), 8);
        flush = 1'b1; flush_id = 2'd0;
        tick();
        flush = 1'b0;
        #1;
        chk("d_r3_vld",  32'(rs1_tag_valid), 1);
        chk("d_r3_tag",  32'(rs1_tag), 5);
        chk("d_r6_vld",  32'(rs2_tag_valid), 1);
        chk("d_r6_tag",  32'(rs2_tag), 12);
        chk("d_tail",    32'(ckpt_id), 0);
        chk("d_full",    32'(ckpt_full), 0);

        // release with nothing outstanding is ignored; four saves fill the ring
        ckpt_release = 1'b1;
        tick();
        ckpt_release = 1'b0;
        ckpt_save = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("e_id%0d", i),   32'(ckpt_id), i);
            chk($sformatf("e_full%0d", i), 32'(ckpt_full), 0);
            tick();
        end
        #1;
        chk("e_full",        32'(ckpt_full), 1);
        chk("e_id_wrap",     32'(ckpt_id), 0);
        tick();
        #1;
        chk("e_ign_full",    32'(ckpt_full), 1);
        chk("e_ign_id",      32'(ckpt_id), 0);
        ckpt_save = 1'b0; ckpt_release = 1'b1;
        tick();
        ckpt_release = 1'b0;
        #1;
        chk("e_rel_full",    32'(ckpt_full), 0);
        chk("e_rel_id",      32'(ckpt_id), 0);
        ckpt_save = 1'b1;
        tick();
        ckpt_save = 1'b0;
        #1;
        chk("e_refill_full", 32'(ckpt_full), 1);
        chk("e_refill_id",   32'(ckpt_id), 1);

        // reset mid-operation discards everything, no write-back
        rs1 = 5'd6; cdb_valid = 2'b01; cdb_tag[0] = 6'd12; rst = 1'b1;
        #1;
        chk("mr_rs1_vld",  32'(rs1_tag_valid), 0);
        chk("mr_rf_we",    32'(rf_we), 0);
        chk("mr_full",     32'(ckpt_full), 0);
        chk("mr_ckpt_id",  32'(ckpt_id), 0);
        tick();
        rst = 1'b0; cdb_valid = 2'b00;

        // checkpointed tag broadcast before flush must not come back
        rd = 5'd1; rd_tag = 6'd2; tag_write_en = 1'b1;
        tick();
        tag_write_en = 1'b0; ckpt_save = 1'b1;
        #1;
        chk("f_ckpt_id", 32'(ckpt_id), 0);
        tick();
        ckpt_save = 1'b0;
        rd = 5'd7; rd_tag = 6'd20; tag_write_en = 1'b1;
        tick();
        tag_write_en = 1'b0; cdb_valid = 2'b01; cdb_tag[0] = 6'd2;
        tick();
        cdb_valid = 2'b00; flush = 1'b1; flush_id = 2'd0;
        tick();
        flush = 1'b0; rs1 = 5'd1; rs2 = 5'd7;
        #1;
        chk("f_r1_vld", 32'(rs1_tag_valid), 0);
        chk("f_r7_vld", 32'(rs2_tag_valid), 0);

        // release + flush same cycle, restored slot also sees that cycle's broadcast
        rd = 5'd8; rd_tag = 6'd30; tag_write_en = 1'b1; ckpt_save = 1'b1;
        #1;
        chk("g_id0", 32'(ckpt_id), 0);
        tick();
        rd = 5'd9; rd_tag = 6'd31;
        #1;
        chk("g_id1", 32'(ckpt_id), 1);
        tick();
        rd = 5'd10; rd_tag = 6'd11;
        #1;
        chk("g_id2", 32'(ckpt_id), 2);
        tick();
        ckpt_save = 1'b0; rd = 5'd11; rd_tag = 6'd40;
        tick();
        tag_write_en = 1'b0;
        ckpt_release = 1'b1; flush = 1'b1; flush_id = 2'd2;
        cdb_valid = 2'b01; cdb_tag[0] = 6'd11;
        #1;
        chk("g_rf_we",  32'(rf_we), 2'b01);
        chk("g_rf_rd0", 32'(rf_rd[0]), 10);
        tick();
        ckpt_release = 1'b0; flush = 1'b0; cdb_valid = 2'b00;
        rs1 = 5'd10; rs2 = 5'd11;
        #1;
        chk("g_r10_vld", 32'(rs1_tag_valid), 0);
        chk("g_r11_vld", 32'(rs2_tag_valid), 0);
        rs1 = 5'd9; rs2 = 5'd8;
        #1;
        chk("g_r9_vld", 32'(rs1_tag_valid), 1);
        chk("g_r9_tag", 32'(rs1_tag), 31);
        chk("g_r8_vld", 32'(rs2_tag_valid), 1);
        chk("g_r8_tag", 32'(rs2_tag), 30);
        chk("g_tail",   32'(ckpt_id), 2);
        chk("g_full",   32'(ckpt_full), 0);
        ckpt_save = 1'b1;
        #1;
        chk("g_s0_id", 32'(ckpt_id), 2);
        tick();
        chk("g_s1_id",   32'(ckpt_id), 3);
        chk("g_s1_full", 32'(ckpt_full), 0);
        tick();
        chk("g_s2_id",   32'(ckpt_id), 0);
        chk("g_s2_full", 32'(ckpt_full), 0);
        tick();
        ckpt_save = 1'b0;
        #1;
        chk("g_end_full", 32'(ckpt_full), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tag_status_table.md
TAG_STATUS_TABLE -- requirements
Module: tag_status_table

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers (power of two, ≥4).
REQ-002 SHALL have parameter TAG_W, default 6, reservation-station tag width.
REQ-003 SHALL have parameter NUM_CDB, default 2, number of common-data-bus broadcast channels.
REQ-004 SHALL have parameter NUM_CKPT, default 4, number of branch checkpoints (power of two).
REQ-005 SHALL have ports, with clock and reset asynchronous, active-high as follows:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_tag  in  NUM_CDB x TAG_W  per-channel broadcast tag
- rf_we  out  NUM_CDB  per-channel register-file write enable
- rf_rd  out  NUM_CDB x log2(NUM_REGS)  per-channel destination register
- rs1 / rs2  in  log2(NUM_REGS)  source register indices
- rs1_tag / rs2_tag  out  TAG_W  pending tag of source
- rs1_tag_valid / rs2_tag_valid  out  1  source pending
- rd  in  log2(NUM_REGS)  dispatch destination
- rd_tag  in  TAG_W  tag allocated to rd
- tag_write_en  in  1  dispatch writes rd entry
- ckpt_save  in  1  snapshot request (branch dispatch)
- ckpt_id  out  log2(NUM_CKPT)  id allocated by a save this cycle
- ckpt_full  out  1  no free checkpoint
- ckpt_release  in  1  free oldest checkpoint (branch resolved correct)
- flush  in  1  mispredict recovery
- flush_id  in  log2(NUM_CKPT)  checkpoint to restore

Function
REQ-006 Entry = {valid, tag}; entry 0 SHALL never become valid; tag_write_en with rd=0 ignored.
REQ-007 rf_rd[c] SHALL be the index of the valid entry whose tag equals cdb_tag[c], combinationally; rf_we[c] = cdb_valid[c] & match found; no match -> rf_rd[c]=0, rf_we[c]=0.
REQ-008 Matching valid entries SHALL be cleared on the next clk edge; multiple channels clear independently in the same cycle.
REQ-009 Read ports SHALL bypass same-cycle CDB: if rsN entry tag matches any valid cdb_tag, rsN_tag_valid=0; rsN_tag still shows the stored tag.
REQ-010 Same-cycle write and clear of the same entry: write SHALL win (entry = {1, rd_tag}); clears to other entries proceed.
REQ-011 ckpt_save SHALL store the table's next-state (after REQ-008/010) into slot at tail pointer; ckpt_id = tail; tail and count increment.
REQ-012 ckpt_save while ckpt_full SHALL be ignored (no state change); dispatcher must stall.
REQ-013 Stored checkpoints SHALL also receive CDB clears every cycle (same matching rule) so no restored tag is stale.
REQ-014 ckpt_release SHALL advance head and decrement count; ignored when count=0.
REQ-015 flush SHALL load the live table from slot flush_id (with same-cycle CDB clears applied), set tail=flush_id, count=(flush_id-head) mod NUM_CKPT; flush overrides tag_write_en and ckpt_save same cycle.
REQ-016 flush with simultaneous ckpt_release SHALL apply release first (head+1) then flush; flush_id equal to released head is an illegal stimulus.
REQ-017 Pointers wrap modulo NUM_CKPT; ckpt_full = (count==NUM_CKPT).

Reset
REQ-018 rst SHALL asynchronously clear all live and checkpoint entries, head=tail=count=0; outputs: rsN_tag_valid=0, rf_we=0, ckpt_full=0, ckpt_id=0.
REQ-019 rst mid-operation SHALL discard all pending tags and checkpoints without further rf_we.

Structure
REQ-020 Shared package SHALL hold the entry struct type and defaults of NUM_REGS, TAG_W, NUM_CDB, NUM_CKPT.
REQ-021 Tag-to-index match SHALL be a sub-module tst_tag_match (one instance per CDB channel).

Verification
REQ-022 Write r5 tag 9, next cycle CDB0 tag 9 -> rf_we[0]=1, rf_rd[0]=5, r5 invalid after edge.
REQ-023 CDB0 tag 3 and CDB1 tag 7 same cycle with r2=3, r4=7 -> both rf_we=1, both entries cleared.
REQ-024 Dispatch r6 tag 12 while CDB clears old r6 tag 4 -> r6 = {1,12}; rs1=6 same cycle reads valid=0 via bypass.
REQ-025 Save ckpt (id 0) with r3 tag 5, then write r3 tag 8, flush id 0 -> r3 = {1,5}, count=0.
REQ-026 Save 4 ckpts -> ckpt_full=1, 5th save ignored; release -> ckpt_full=0; save -> ckpt_id=0 (wrap).
REQ-027 Ckpt holds r1 tag 2, CDB tag 2 broadcasts, then flush -> r1 invalid.
